spi_reg_ctrl: RTL and testbench

- Register-map controller that sequences the byte stream from spi_slave into 7-bit-addressed register reads and writes, with burst auto-increment.
- Owns the FPGA configuration registers: bootloader force pin, UART inversion and telemetry connector select.
- Drives the tx byte back to spi_slave.
- Sits in Top between spi0_inst and the pins/config consumers.

---
 rtl/spi_reg_pkg.sv | 26 ++
 rtl/sync_edge_det.sv | 28 ++
 rtl/spi_reg_ctrl.sv | 147 ++++++++++++++
 tb/tb_spi_reg_ctrl.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_pkg.sv
// Shared definitions for the SPI register-map controller: register addresses,
// FSM state encoding and field masks.
package spi_reg_pkg;

    localparam logic [6:0] REG_FW_VER    = 7'h00;
    localparam logic [6:0] REG_FORCE_BT  = 7'h01;
    localparam logic [6:0] REG_UART_INV  = 7'h02;
    localparam logic [6:0] REG_TELEM_SEL = 7'h03;
    localparam logic [6:0] REG_SCRATCH   = 7'h04;
    localparam logic [6:0] REG_ERR_CNT   = 7'h05;

    localparam logic [7:0] FORCE_BT_MASK = 8'h01;
    localparam logic [7:0] ERR_CNT_MAX   = 8'hFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        DATA = 2'd2
    } state_e;

    // Writes to the read-only firmware version or to any unmapped address are errors.
    function automatic logic is_err_addr(input logic [6:0] addr);
        return (addr == REG_FW_VER) || (addr > REG_ERR_CNT);
    endfunction

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser followed by an edge register; emits a one-cycle pulse on
// each synchronised rising edge of a level arriving from another clock domain.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic rise
);

    logic [2:0] sync_q;
    logic [2:0] sync_d;

    always_comb begin
        sync_d = {sync_q[1:0], din};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= sync_d;
        end
    end

    // sync_q[1] is the last metastability-safe stage, sync_q[2] its delayed copy.
    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI register-map controller: sequences spi_slave bytes into 7-bit register
// reads/writes. Burst auto-increment is enabled by defining SPI_REG_AUTOINC_EN.
module spi_reg_ctrl
    import spi_reg_pkg::*;
#(
    parameter logic [7:0] UART_INV_RST  = 8'h00,
    parameter logic [7:0] TELEM_SEL_RST = 8'h00,
    parameter logic [7:0] SCRATCH_RST   = 8'hA5
) (
    input  logic       clk_core,
    input  logic       reset_n,
    input  logic [7:0] fpga_firmware_version,
    input  logic       spi_transaction_begin,
    input  logic       spi_rx_byte_available,
    input  logic [7:0] spi_rx_byte,
    output logic [7:0] spi_tx_byte,
    output logic       bootloader_force_pin,
    output logic [7:0] uart_inverted,
    output logic [7:0] telemetry_con_sel,
    output logic       busy
);

    state_e     state_q, state_d;
    logic       rw_q, rw_d;
    logic [6:0] addr_q, addr_d;
    logic [7:0] tx_q, tx_d;
    logic [7:0] force_bt_q, force_bt_d;
    logic [7:0] uart_inv_q, uart_inv_d;
    logic [7:0] telem_sel_q, telem_sel_d;
    logic [7:0] scratch_q, scratch_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    logic       rx_evt;
    logic [6:0] next_addr;
    logic [6:0] rd_addr;
    logic [7:0] rd_data;

    sync_edge_det u_rx_sync (
        .clk   (clk_core),
        .rst_n (reset_n),
        .din   (spi_rx_byte_available),
        .rise  (rx_evt)
    );

`ifdef SPI_REG_AUTOINC_EN
    assign next_addr = addr_q + 7'd1;
`else
    assign next_addr = addr_q;
`endif

    // Command reads use the address in the incoming byte; burst reads use the advanced address.
    assign rd_addr = (state_q == CMD) ? spi_rx_byte[6:0] : next_addr;

    always_comb begin
        rd_data = 8'h00;
        case (rd_addr)
            REG_FW_VER:    rd_data = fpga_firmware_version;
            REG_FORCE_BT:  rd_data = force_bt_q & FORCE_BT_MASK;
            REG_UART_INV:  rd_data = uart_inv_q;
            REG_TELEM_SEL: rd_data = telem_sel_q;
            REG_SCRATCH:   rd_data = scratch_q;
            REG_ERR_CNT:   rd_data = err_cnt_q;
            default:       rd_data = 8'h00;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        tx_d        = tx_q;
        force_bt_d  = force_bt_q;
        uart_inv_d  = uart_inv_q;
        telem_sel_d = telem_sel_q;
        scratch_d   = scratch_q;
        err_cnt_d   = err_cnt_q;

        // A new transaction always wins, including over a byte arriving the same cycle.
        if (spi_transaction_begin) begin
            state_d = CMD;
            tx_d    = 8'h00;
        end else if (rx_evt) begin
            case (state_q)
                CMD: begin
                    rw_d    = spi_rx_byte[7];
                    addr_d  = spi_rx_byte[6:0];
                    state_d = DATA;
                    if (!spi_rx_byte[7]) begin
                        tx_d = rd_data;
                    end
                end
                DATA: begin
                    addr_d = next_addr;
                    if (rw_q) begin
                        case (addr_q)
                            REG_FORCE_BT:  force_bt_d  = spi_rx_byte & FORCE_BT_MASK;
                            REG_UART_INV:  uart_inv_d  = spi_rx_byte;
                            REG_TELEM_SEL: telem_sel_d = spi_rx_byte;
                            REG_SCRATCH:   scratch_d   = spi_rx_byte;
                            REG_ERR_CNT:   err_cnt_d   = 8'h00;
                            default: begin
                                if (is_err_addr(addr_q) && (err_cnt_q != ERR_CNT_MAX)) begin
                                    err_cnt_d = err_cnt_q + 8'd1;
                                end
                            end
                        endcase
                    end else begin
                        tx_d = rd_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clk_core or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            rw_q        <= 1'b0;
            addr_q      <= 7'h00;
            tx_q        <= 8'h00;
            force_bt_q  <= 8'h00;
            uart_inv_q  <= UART_INV_RST;
            telem_sel_q <= TELEM_SEL_RST;
            scratch_q   <= SCRATCH_RST;
            err_cnt_q   <= 8'h00;
        end else begin
            state_q     <= state_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            tx_q        <= tx_d;
            force_bt_q  <= force_bt_d;
            uart_inv_q  <= uart_inv_d;
            telem_sel_q <= telem_sel_d;
            scratch_q   <= scratch_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign spi_tx_byte          = tx_q;
    assign bootloader_force_pin = force_bt_q[0];
    assign uart_inverted        = uart_inv_q;
    assign telemetry_con_sel    = telem_sel_q;
    assign busy                 = (state_q != IDLE);

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Scoreboard bench for spi_reg_ctrl: directed register-map scenarios plus random
// transactions, checked against a register-level reference model.
module tb_spi_reg_ctrl;

`ifdef SPI_REG_AUTOINC_EN
    localparam int STEP = 1;
`else
    localparam int STEP = 0;
`endif

    localparam logic [7:0] FW_VERSION = 8'hC2;

    logic       clk_core = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] fpga_firmware_version = FW_VERSION;
    logic       spi_transaction_begin = 1'b0;
    logic       spi_rx_byte_available = 1'b0;
    logic [7:0] spi_rx_byte = 8'h00;
    logic [7:0] spi_tx_byte;
    logic       bootloader_force_pin;
    logic [7:0] uart_inverted;
    logic [7:0] telemetry_con_sel;
    logic       busy;

    spi_reg_ctrl dut (
        .clk_core              (clk_core),
        .reset_n               (reset_n),
        .fpga_firmware_version (fpga_firmware_version),
        .spi_transaction_begin (spi_transaction_begin),
        .spi_rx_byte_available (spi_rx_byte_available),
        .spi_rx_byte           (spi_rx_byte),
        .spi_tx_byte           (spi_tx_byte),
        .bootloader_force_pin  (bootloader_force_pin),
        .uart_inverted         (uart_inverted),
        .telemetry_con_sel     (telemetry_con_sel),
        .busy                  (busy)
    );

    // 50 MHz core clock
    always #10 clk_core = ~clk_core;

    typedef struct packed {
        logic [7:0] tx;
        logic       frc;
        logic [7:0] uart;
        logic [7:0] telem;
        logic       bsy;
    } obs_t;

    obs_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    logic  snap_req = 1'b0;

    // Reference model: register contents plus transaction phase (0 idle, 1 await command, 2 data)
    logic [7:0] m_uart, m_telem, m_scratch, m_err, m_tx;
    logic       m_force, m_busy, m_rw;
    int         m_phase, m_addr;

    function automatic logic [7:0] m_read(input int a);
        case (a)
            0: return FW_VERSION;
            1: return {7'b0, m_force};
            2: return m_uart;
            3: return m_telem;
            4: return m_scratch;
            5: return m_err;
            default: return 8'h00;
        endcase
    endfunction

    task automatic model_reset();
        m_force = 1'b0; m_uart = 8'h00; m_telem = 8'h00; m_scratch = 8'hA5;
        m_err = 8'h00; m_tx = 8'h00; m_busy = 1'b0; m_rw = 1'b0;
        m_phase = 0; m_addr = 0;
    endtask

    task automatic model_write(input int a, input logic [7:0] b);
        if (a == 1) m_force = b[0];
        else if (a == 2) m_uart = b;
        else if (a == 3) m_telem = b;
        else if (a == 4) m_scratch = b;
        else if (a == 5) m_err = 8'h00;
        else if (m_err < 8'hFF) m_err = m_err + 8'd1;
    endtask

    task automatic model_byte(input logic [7:0] b);
        if (m_phase == 1) begin
            m_rw = b[7];
            m_addr = int'(b[6:0]);
            m_phase = 2;
            if (!m_rw) m_tx = m_read(m_addr);
        end else if (m_phase == 2) begin
            if (m_rw) model_write(m_addr, b);
            m_addr = (m_addr + STEP) % 128;
            if (!m_rw) m_tx = m_read(m_addr);
        end
    endtask

    task automatic push_expect(input string name);
        exp_q.push_back('{tx: m_tx, frc: m_force, uart: m_uart, telem: m_telem, bsy: m_busy});
        name_q.push_back(name);
    endtask

    task automatic snap(input string name);
        push_expect(name);
        snap_req = 1'b1;
        #1 snap_req = 1'b0;
        repeat (2) @(negedge clk_core);
    endtask

    // One SPI byte: raise available, hold long enough for the synchroniser, then drop it
    task automatic applyStimulus(input logic [7:0] b, input string name);
        @(negedge clk_core);
        spi_rx_byte = b;
        spi_rx_byte_available = 1'b1;
        repeat (6) @(negedge clk_core);
        model_byte(b);
        push_expect(name);
        spi_rx_byte_available = 1'b0;
        repeat (4) @(negedge clk_core);
    endtask

    task automatic send_begin();
        @(negedge clk_core);
        spi_transaction_begin = 1'b1;
        @(negedge clk_core);
        spi_transaction_begin = 1'b0;
        m_phase = 1; m_tx = 8'h00; m_busy = 1'b1;
        snap("begin");
    endtask

    // Byte whose synchronised edge lands on the same cycle as a begin pulse
    task automatic byte_with_begin(input logic [7:0] b);
        @(negedge clk_core);
        spi_rx_byte = b;
        spi_rx_byte_available = 1'b1;
        repeat (2) @(negedge clk_core);
        spi_transaction_begin = 1'b1;
        @(negedge clk_core);
        spi_transaction_begin = 1'b0;
        m_phase = 1; m_tx = 8'h00; m_busy = 1'b1;
        repeat (3) @(negedge clk_core);
        push_expect("begin_vs_byte");
        spi_rx_byte_available = 1'b0;
        repeat (4) @(negedge clk_core);
    endtask

    task automatic checkOutput(input obs_t e, input string name);
        obs_t act;
        act = '{tx: spi_tx_byte, frc: bootloader_force_pin, uart: uart_inverted,
                telem: telemetry_con_sel, bsy: busy};
        vectors++;
        if (act !== e) begin
            miscompares++;
            $display("[TB] FAIL %s: got tx=%h force=%b uart=%h telem=%h busy=%b, expected tx=%h force=%b uart=%h telem=%h busy=%b",
                     name, act.tx, act.frc, act.uart, act.telem, act.bsy,
                     e.tx, e.frc, e.uart, e.telem, e.bsy);
        end
    endtask

    // Monitor: whenever the DUT has consumed a byte (or a snapshot is requested), pop and compare
    initial begin
        obs_t  e;
        string n;
        forever begin
            @(negedge spi_rx_byte_available or posedge snap_req);
            @(negedge clk_core);
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("[TB] FAIL scoreboard: DUT output presented with no expected entry queued");
            end else begin
                e = exp_q.pop_front();
                n = name_q.pop_front();
                checkOutput(e, n);
            end
        end
    end

    initial begin
        logic [7:0] cmd;
        int a, nbytes;

        model_reset();
        repeat (3) @(negedge clk_core);
        snap("reset_held");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_core);
        snap("reset_released");

        applyStimulus(8'h82, "idle_byte_ignored");

        send_begin(); applyStimulus(8'h04, "read_scratch_rst");
        send_begin(); applyStimulus(8'h00, "read_fw_ver");
        send_begin(); applyStimulus(8'h85, "cmd_wr_errcnt"); applyStimulus(8'h3C, "wr_errcnt");
        send_begin(); applyStimulus(8'h05, "read_errcnt_zero");

        send_begin(); applyStimulus(8'h81, "cmd_wr_force");
        applyStimulus(8'h01, "burst_wr0");
        applyStimulus(8'h0F, "burst_wr1");
        applyStimulus(8'h55, "burst_wr2");

        send_begin(); applyStimulus(8'h80, "cmd_wr_fw");
        applyStimulus(8'hFF, "wr_fw_error");
        send_begin(); applyStimulus(8'h05, "read_errcnt_one");
        send_begin(); applyStimulus(8'h00, "read_fw_intact");

        for (int i = 0; i < 300; i++) begin
            send_begin();
            applyStimulus(8'hFF, "cmd_wr_7f");
            applyStimulus(8'($urandom), "wr_7f_error");
        end
        send_begin(); applyStimulus(8'h05, "read_errcnt_sat");
        send_begin(); applyStimulus(8'h85, "cmd_clr_err"); applyStimulus(8'h00, "clr_err");
        send_begin(); applyStimulus(8'h05, "read_errcnt_cleared");

        send_begin(); applyStimulus(8'hFF, "cmd_wr_wrap");
        applyStimulus(8'h11, "wrap_wr0");
        applyStimulus(8'h22, "wrap_wr1");
        send_begin(); applyStimulus(8'h05, "read_errcnt_wrap");
        send_begin(); applyStimulus(8'h00, "read_fw_after_wrap");

        send_begin(); applyStimulus(8'h01, "cmd_rd_burst");
        for (int i = 0; i < 5; i++) applyStimulus(8'($urandom), "burst_rd");
        send_begin(); applyStimulus(8'h7F, "cmd_rd_7f");
        applyStimulus(8'h00, "rd_wrap");

        send_begin(); applyStimulus(8'h82, "cmd_wr_uart");
        applyStimulus(8'h77, "wr_uart");
        byte_with_begin(8'h99);
        applyStimulus(8'h02, "cmd_after_drop");

        for (int t = 0; t < 40; t++) begin
            a = $urandom_range(0, 9);
            if (a > 7) a = 8'h7E + (a - 8);
            cmd = {1'($urandom), 7'(a)};
            nbytes = $urandom_range(1, 4);
            send_begin();
            applyStimulus(cmd, "rand_cmd");
            for (int k = 0; k < nbytes; k++) applyStimulus(8'($urandom), "rand_data");
        end

        send_begin(); applyStimulus(8'h82, "cmd_pre_reset");
        applyStimulus(8'h3A, "wr_pre_reset");
        @(negedge clk_core);
        reset_n = 1'b0;
        model_reset();
        snap("reset_mid_burst");
        reset_n = 1'b1;
        repeat (2) @(negedge clk_core);
        snap("after_mid_reset");
        send_begin(); applyStimulus(8'h04, "read_scratch_after_reset");

        for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk_core);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d expected entries never observed, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
